// File: rtl/rsa_keygen_core_if.sv
// Start/done handshake plus key-generation results for rsa_keygen_core.
// The master drives the request; the slave (the core) returns status and results.
interface rsa_keygen_core_if #(
    parameter int W = 8
);
    logic           start;
    logic [W-1:0]   p;
    logic [W-1:0]   q;
    logic           busy;
    logic           done;
    logic           err;
    logic [1:0]     err_code;
    logic [2*W-1:0] n;
    logic [2*W-1:0] phi;
    logic [2*W-1:0] e;
    logic [2*W-1:0] d;
    logic [2:0]     state;

    modport master (
        output start, p, q,
        input  busy, done, err, err_code, n, phi, e, d, state
    );

    modport slave (
        input  start, p, q,
        output busy, done, err, err_code, n, phi, e, d, state
    );
endinterface

// File: rtl/rsa_keygen_core.sv
// Iterative RSA key generator: n, phi by shift-add, e by subtractive gcd, d by stepping e*d mod phi.
// Optional macro RSA_KEYGEN_TIMEOUT_EN adds a busy-cycle watchdog (err_code 3).
module rsa_keygen_core #(
    parameter int W              = 8,
    parameter int E_MIN          = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    rsa_keygen_core_if.slave  bus
);
    localparam int W2 = 2 * W;
    localparam int CW = $clog2(W + 1);
    localparam logic [W2-1:0] EMIN_V = W2'(E_MIN);
    localparam logic [W2-1:0] ONE2   = W2'(1);
    localparam logic [W2:0]   ONER   = (W2 + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_ECHK = 3'd2,
        S_GCD  = 3'd3,
        S_INV  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   mc_n_q, mc_n_d, mc_phi_q, mc_phi_d;
    logic [W-1:0]    ml_n_q, ml_n_d, ml_phi_q, ml_phi_d;
    logic [W2-1:0]   acc_n_q, acc_n_d, acc_phi_q, acc_phi_d;
    logic [W2-1:0]   n_q, n_d, phi_q, phi_d, e_q, e_d, d_q, d_d;
    logic [W2-1:0]   a_q, a_d, b_q, b_d;
    logic [W2:0]     r_q, r_d;
    logic [1:0]      ec_q, ec_d;

    logic [W2-1:0]   acc_n_sum, acc_phi_sum, d_inc;
    logic [W2:0]     r_sum, r_red;
    logic            busy_w;

    assign busy_w = (state_q == S_MUL) || (state_q == S_ECHK) ||
                    (state_q == S_GCD) || (state_q == S_INV);

`ifdef RSA_KEYGEN_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mc_n_q    <= '0;
            mc_phi_q  <= '0;
            ml_n_q    <= '0;
            ml_phi_q  <= '0;
            acc_n_q   <= '0;
            acc_phi_q <= '0;
            n_q       <= '0;
            phi_q     <= '0;
            e_q       <= '0;
            d_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            ec_q      <= '0;
`ifdef RSA_KEYGEN_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mc_n_q    <= mc_n_d;
            mc_phi_q  <= mc_phi_d;
            ml_n_q    <= ml_n_d;
            ml_phi_q  <= ml_phi_d;
            acc_n_q   <= acc_n_d;
            acc_phi_q <= acc_phi_d;
            n_q       <= n_d;
            phi_q     <= phi_d;
            e_q       <= e_d;
            d_q       <= d_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            ec_q      <= ec_d;
`ifdef RSA_KEYGEN_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mc_n_d    = mc_n_q;
        mc_phi_d  = mc_phi_q;
        ml_n_d    = ml_n_q;
        ml_phi_d  = ml_phi_q;
        acc_n_d   = acc_n_q;
        acc_phi_d = acc_phi_q;
        n_d       = n_q;
        phi_d     = phi_q;
        e_d       = e_q;
        d_d       = d_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        ec_d      = ec_q;

        acc_n_sum   = acc_n_q + (ml_n_q[0] ? mc_n_q : '0);
        acc_phi_sum = acc_phi_q + (ml_phi_q[0] ? mc_phi_q : '0);
        // Extra top bit keeps r + e exact before the conditional modular reduction.
        r_sum = r_q + {1'b0, e_q};
        r_red = (r_sum >= {1'b0, phi_q}) ? (r_sum - {1'b0, phi_q}) : r_sum;
        d_inc = d_q + ONE2;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    mc_n_d    = W2'(bus.p);
                    ml_n_d    = bus.q;
                    mc_phi_d  = W2'(bus.p - W'(1));
                    ml_phi_d  = bus.q - W'(1);
                    acc_n_d   = '0;
                    acc_phi_d = '0;
                    cnt_d     = '0;
                    n_d       = '0;
                    phi_d     = '0;
                    e_d       = '0;
                    d_d       = '0;
                    ec_d      = 2'd0;
                    if (bus.p[W-1:1] == '0 || bus.q[W-1:1] == '0) begin
                        state_d = S_ERR;
                        ec_d    = 2'd1;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_n_d   = acc_n_sum;
                acc_phi_d = acc_phi_sum;
                mc_n_d    = mc_n_q << 1;
                mc_phi_d  = mc_phi_q << 1;
                ml_n_d    = ml_n_q >> 1;
                ml_phi_d  = ml_phi_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    n_d     = acc_n_sum;
                    phi_d   = acc_phi_sum;
                    e_d     = EMIN_V;
                    state_d = S_ECHK;
                end
            end
            S_ECHK: begin
                if (e_q >= phi_q) begin
                    state_d = S_ERR;
                    ec_d    = 2'd2;
                end else begin
                    a_d     = phi_q;
                    b_d     = e_q;
                    state_d = S_GCD;
                end
            end
            S_GCD: begin
                if (a_q == b_q) begin
                    if (a_q == ONE2) begin
                        r_d     = {1'b0, e_q};
                        d_d     = ONE2;
                        state_d = S_INV;
                    end else begin
                        e_d     = e_q + ONE2;
                        state_d = S_ECHK;
                    end
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            S_INV: begin
                if (r_q == ONER) begin
                    state_d = S_DONE;
                end else begin
                    r_d = r_red;
                    d_d = d_inc;
                    if (d_inc == phi_q) begin
                        state_d = S_ERR;
                        ec_d    = 2'd2;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef RSA_KEYGEN_TIMEOUT_EN
        // Watchdog overrides whatever transition the busy state picked this cycle.
        tmo_d = tmo_q;
        if (busy_w) begin
            tmo_d = tmo_q + 32'd1;
            if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_ERR;
                ec_d    = 2'd3;
            end
        end else if (bus.start) begin
            tmo_d = '0;
        end
`endif
    end

    always_comb begin
        bus.busy     = busy_w;
        bus.done     = (state_q == S_DONE);
        bus.err      = (state_q == S_ERR);
        bus.err_code = ec_q;
        bus.n        = n_q;
        bus.phi      = phi_q;
        bus.e        = e_q;
        bus.d        = d_q;
        bus.state    = state_q;
    end
endmodule
